// File: rtl/box_pkg.sv
// Screen geometry, box defaults and FSM encoding shared between the box
// position controller and the pixel compositor.
package box_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned BOX_W    = 100;
    localparam int unsigned BOX_H    = 100;

    typedef enum logic {
        StIdle = 1'b0,
        StMove = 1'b1
    } state_e;

    // Saturate a signed candidate position into [0, hi] so the box never wraps.
    function automatic logic [9:0] clamp_pos(input logic signed [11:0] pos,
                                             input int unsigned hi);
        logic signed [11:0] hi_s;
        hi_s = signed'(12'(hi));
        if (pos < 0) begin
            return '0;
        end else if (pos > hi_s) begin
            return 10'(hi);
        end else begin
            return pos[9:0];
        end
    endfunction

endpackage

// File: rtl/box_position_ctrl_if.sv
// Button/vsync inputs and box position outputs of the box position controller.
interface box_position_ctrl_if;

    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       vsync;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic       frame_tick;
    logic       moving;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, vsync,
        input  box_x, box_y, frame_tick, moving
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, vsync,
        output box_x, box_y, frame_tick, moving
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability counter; the accepted level
// only follows the synced level after it has differed for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_25mhz,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_25mhz or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/box_position_ctrl.sv
// Turns debounced direction buttons and vsync into a clamped box position that
// moves at most once per frame, with a speed ramp while a direction is held.
module box_position_ctrl #(
    parameter int unsigned H_ACTIVE        = box_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE        = box_pkg::V_ACTIVE,
    parameter int unsigned BOX_W           = box_pkg::BOX_W,
    parameter int unsigned BOX_H           = box_pkg::BOX_H,
    parameter int unsigned INIT_X          = 270,
    parameter int unsigned INIT_Y          = 190,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned RAMP_FRAMES     = 16,
    parameter int unsigned MAX_STEP        = 4
) (
    input logic                clk_25mhz,
    input logic                rst,
    box_position_ctrl_if.slave bus
);

    import box_pkg::*;

    localparam int unsigned HoldMax = (MAX_STEP - 1) * RAMP_FRAMES;
    localparam int unsigned HoldW   = $clog2(HoldMax + 2);
    localparam int unsigned XMax    = H_ACTIVE - BOX_W;
    localparam int unsigned YMax    = V_ACTIVE - BOX_H;

    logic up, down, left, right;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk_25mhz(clk_25mhz), .rst(rst), .raw(bus.btn_up), .level(up)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk_25mhz(clk_25mhz), .rst(rst), .raw(bus.btn_down), .level(down)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk_25mhz(clk_25mhz), .rst(rst), .raw(bus.btn_left), .level(left)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk_25mhz(clk_25mhz), .rst(rst), .raw(bus.btn_right), .level(right)
    );

    // vsync edge detector; armed only once a genuine synced low has been seen,
    // so vsync held high across reset release cannot fake a rising edge.
    logic       vs_s1_q, vs_s2_q, vs_prev_q, vs_armed_q, tick_q;
    logic [1:0] vs_valid_q;

    always_ff @(posedge clk_25mhz or negedge rst) begin
        if (!rst) begin
            vs_s1_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            vs_prev_q  <= 1'b0;
            vs_valid_q <= '0;
            vs_armed_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            vs_s1_q    <= bus.vsync;
            vs_s2_q    <= vs_s1_q;
            vs_prev_q  <= vs_s2_q;
            vs_valid_q <= {vs_valid_q[0], 1'b1};
            if (vs_valid_q[1] && !vs_s2_q) begin
                vs_armed_q <= 1'b1;
            end
            tick_q <= vs_s2_q & ~vs_prev_q & vs_armed_q;
        end
    end

    state_e           state_q;
    logic [HoldW-1:0] hold_q;
    logic [9:0]       x_q, y_q;
    logic             moving_q;

    logic               any_dir;
    int unsigned        step_i;
    logic signed [11:0] step_s, dx, dy, nx, ny;
    logic [9:0]         x_next, y_next;

    always_comb begin
        any_dir = up | down | left | right;
        step_i  = 32'(hold_q) / RAMP_FRAMES + 1;
        if (step_i > MAX_STEP) begin
            step_i = MAX_STEP;
        end
        step_s = signed'(12'(step_i));
        dx     = signed'(12'(right)) - signed'(12'(left));
        dy     = signed'(12'(down)) - signed'(12'(up));
        nx     = signed'({2'b00, x_q}) + dx * step_s;
        ny     = signed'({2'b00, y_q}) + dy * step_s;
        x_next = clamp_pos(nx, XMax);
        y_next = clamp_pos(ny, YMax);
    end

    always_ff @(posedge clk_25mhz or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            x_q      <= 10'(INIT_X);
            y_q      <= 10'(INIT_Y);
            moving_q <= 1'b0;
        end else if (tick_q) begin
            if (any_dir) begin
                x_q      <= x_next;
                y_q      <= y_next;
                moving_q <= 1'b1;
                state_q  <= StMove;
                unique case (state_q)
                    StIdle: hold_q <= '0;
                    StMove: if (hold_q != HoldW'(HoldMax)) hold_q <= hold_q + 1'b1;
                    default: hold_q <= '0;
                endcase
            end else begin
                state_q  <= StIdle;
                hold_q   <= '0;
                moving_q <= 1'b0;
            end
        end
    end

    assign bus.box_x      = x_q;
    assign bus.box_y      = y_q;
    assign bus.frame_tick = tick_q;
    assign bus.moving     = moving_q;

endmodule

// File: tb/tb_box_position_ctrl.sv
// Directed bench for box_position_ctrl: debounce, frame tick timing, ramp,
// clamping, opposing buttons and mid-frame reset with vsync held high.
module tb_box_position_ctrl;

    logic clk_25mhz = 1'b0;
    logic rst       = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    always #5 clk_25mhz = ~clk_25mhz;

    box_position_ctrl_if bus ();

    box_position_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .RAMP_FRAMES    (16),
        .MAX_STEP       (4)
    ) dut (
        .clk_25mhz(clk_25mhz),
        .rst      (rst),
        .bus      (bus)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_25mhz);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One vsync pulse; tick must appear exactly 3 clocks after the raw rise,
    // and the new position is checked the cycle after the tick.
    task automatic frame(input bit chk_pos, input int ex, input int ey, input bit emv);
        bus.vsync = 1'b1;
        step(2);
        check("tick_early", 32'(bus.frame_tick), 0);
        step(1);
        check("tick", 32'(bus.frame_tick), 1);
        step(1);
        check("tick_pulse", 32'(bus.frame_tick), 0);
        if (chk_pos) begin
            check("box_x", 32'(bus.box_x), 32'(ex));
            check("box_y", 32'(bus.box_y), 32'(ey));
            check("moving", 32'(bus.moving), 32'(emv));
        end
        bus.vsync = 1'b0;
        step(16);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame(1'b0, 0, 0, 1'b0);
        end
    endtask

    initial begin
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.vsync     = 1'b0;
        step(3);
        check("rst_x", 32'(bus.box_x), 270);
        check("rst_y", 32'(bus.box_y), 190);
        check("rst_tick", 32'(bus.frame_tick), 0);
        check("rst_moving", 32'(bus.moving), 0);
        rst = 1'b1;
        step(8);

        // Idle frames: no motion
        for (int i = 0; i < 5; i++) begin
            frame(1'b1, 270, 190, 1'b0);
        end

        // Short glitch is filtered, a held press moves one pixel
        bus.btn_right = 1'b1;
        step(5);
        bus.btn_right = 1'b0;
        step(16);
        frame(1'b1, 270, 190, 1'b0);
        bus.btn_right = 1'b1;
        step(20);
        frame(1'b1, 271, 190, 1'b1);

        // Ramp: frame 1 step 1 (hold=0), frames 2-17 step 1, 18-33 step 2, 34-40 step 3
        frames(15);
        frame(1'b1, 287, 190, 1'b1);
        frames(15);
        frame(1'b1, 319, 190, 1'b1);
        frames(6);
        frame(1'b1, 340, 190, 1'b1);

        bus.btn_right = 1'b0;
        step(16);
        frame(1'b1, 340, 190, 1'b0);

        // Left to the edge: 339, 323, 291, 243, then step 4 down to 3, clamp to 0
        bus.btn_left = 1'b1;
        step(16);
        frame(1'b1, 339, 190, 1'b1);
        frames(15);
        frame(1'b1, 323, 190, 1'b1);
        frames(15);
        frame(1'b1, 291, 190, 1'b1);
        frames(15);
        frame(1'b1, 243, 190, 1'b1);
        frames(59);
        frame(1'b1, 3, 190, 1'b1);
        frame(1'b1, 0, 190, 1'b1);
        frame(1'b1, 0, 190, 1'b1);
        frame(1'b1, 0, 190, 1'b1);

        bus.btn_left = 1'b0;
        step(16);
        frame(1'b1, 0, 190, 1'b0);

        // Down to the bottom: 191, 207, 239, 287, 379, clamp at 380
        bus.btn_down = 1'b1;
        step(16);
        frame(1'b1, 0, 191, 1'b1);
        frames(15);
        frame(1'b1, 0, 207, 1'b1);
        frames(15);
        frame(1'b1, 0, 239, 1'b1);
        frames(15);
        frame(1'b1, 0, 287, 1'b1);
        frames(22);
        frame(1'b1, 0, 379, 1'b1);
        frame(1'b1, 0, 380, 1'b1);
        frame(1'b1, 0, 380, 1'b1);
        frame(1'b1, 0, 380, 1'b1);

        bus.btn_down = 1'b0;
        step(16);
        frame(1'b1, 0, 380, 1'b0);

        // Opposing vertical buttons cancel while horizontal still moves
        bus.btn_up    = 1'b1;
        bus.btn_down  = 1'b1;
        bus.btn_right = 1'b1;
        step(16);
        frame(1'b1, 1, 380, 1'b1);
        frame(1'b1, 2, 380, 1'b1);

        // Mid-frame reset while moving, vsync held high across release
        bus.vsync = 1'b1;
        step(2);
        check("pre_rst_moving", 32'(bus.moving), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_x", 32'(bus.box_x), 270);
        check("mid_rst_y", 32'(bus.box_y), 190);
        check("mid_rst_moving", 32'(bus.moving), 0);
        check("mid_rst_tick", 32'(bus.frame_tick), 0);
        step(3);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check("no_tick_vsync_high", 32'(bus.frame_tick), 0);
        end
        check("post_rst_x", 32'(bus.box_x), 270);
        bus.vsync = 1'b0;
        step(16);
        frame(1'b1, 271, 190, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
